// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// word geometry and the byte-lane insertion helper.
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  // Insert a byte into lane idx of a 32-bit word (lane 0 is the LSB).
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [7:0]  b,
                                             input logic [IDX_W-1:0] idx);
    logic [31:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: collects up to four bytes into a 32-bit word,
// leaving unfilled upper lanes at zero, and flags when the word is complete.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic [31:0] o_word,
  output logic        o_full
);

  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_word;
  logic             w_full;

  // Word completes on the fourth byte or on an early last byte.
  always_comb begin
    w_full = i_accept && ((r_idx == IDX_W'(WORD_BYTES - 1)) || i_last);
  end

  // Byte index and word buffer; clear wins over a (never concurrent) accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      r_word <= place_byte(r_word, i_byte, r_idx);
      if (!w_full) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign o_word = r_word;
  assign o_full = w_full;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: accepts a byte stream, packs it into
// little-endian words and writes them to consecutive word addresses while
// holding the core in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          N    = 8,
  parameter int unsigned BASE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         rx_last,
  output logic         rx_ready,
  output logic         WE,
  output logic [N-1:0] WA,
  output logic [31:0]  WD,
  output logic         cpu_hold,
  output logic         done,
  output logic         err,
  output logic [N-2:0] words
);

  localparam logic [N-1:0] BASE_A = BASE[N-1:0];
  localparam logic [N-1:0] STEP_A = N'(WORD_BYTES);
  // Highest word-aligned address; writing here ends the session unless last.
  localparam logic [N-1:0] TOP_A  = {{(N-2){1'b1}}, 2'b00};

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_addr;
  logic [N-2:0] r_words;
  logic         r_last_seen;
  logic [N-1:0] r_wa_hold;
  logic [31:0]  r_wd_hold;

  logic         w_rx_ready;
  logic         w_we;
  logic         w_hold;
  logic         w_done;
  logic         w_err;
  logic         w_accept;
  logic         w_start_ok;
  logic         w_clear;
  logic [31:0]  w_word;
  logic         w_full;

  assign w_accept   = rx_valid && w_rx_ready;
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_clear    = w_start_ok || (r_state == WRITE);

  imem_loader_byte_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_accept (w_accept),
    .i_byte   (rx_data),
    .i_last   (rx_last),
    .o_word   (w_word),
    .o_full   (w_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_state_next = r_state;
    w_rx_ready   = 1'b0;
    w_we         = 1'b0;
    w_hold       = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = LOAD;
      end
      LOAD: begin
        w_rx_ready = 1'b1;
        w_hold     = 1'b1;
        if (w_full) w_state_next = WRITE;
      end
      WRITE: begin
        w_we   = 1'b1;
        w_hold = 1'b1;
        if (r_last_seen)          w_state_next = DONE;
        else if (r_addr == TOP_A) w_state_next = ERR;
        else                      w_state_next = LOAD;
      end
      DONE: begin
        w_done = 1'b1;
        if (start) w_state_next = LOAD;
      end
      ERR: begin
        w_err  = 1'b1;
        w_hold = 1'b1;
        if (start) w_state_next = LOAD;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Address counter, word count, last-byte flag and write-port hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= BASE_A;
      r_words     <= '0;
      r_last_seen <= 1'b0;
      r_wa_hold   <= BASE_A;
      r_wd_hold   <= '0;
    end else begin
      if (w_start_ok) begin
        r_addr      <= BASE_A;
        r_words     <= '0;
        r_last_seen <= 1'b0;
      end
      if ((r_state == LOAD) && w_full) begin
        r_last_seen <= rx_last;
      end
      if (r_state == WRITE) begin
        r_words     <= r_words + 1'b1;
        r_wa_hold   <= r_addr;
        r_wd_hold   <= w_word;
        r_last_seen <= 1'b0;
        if (!r_last_seen && (r_addr != TOP_A)) begin
          r_addr <= r_addr + STEP_A;
        end
      end
    end
  end

  // During WRITE the port shows the live address/word; afterwards it holds them.
  assign WA       = (r_state == WRITE) ? r_addr : r_wa_hold;
  assign WD       = (r_state == WRITE) ? w_word : r_wd_hold;
  assign WE       = w_we;
  assign rx_ready = w_rx_ready;
  assign cpu_hold = w_hold;
  assign done     = w_done;
  assign err      = w_err;
  assign words    = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized
// byte streams compared against a chunk-level model of the load session.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_last = 1'b0;

  logic        a_rx_ready, a_WE, a_cpu_hold, a_done, a_err;
  logic [7:0]  a_WA;
  logic [31:0] a_WD;
  logic [6:0]  a_words;
  logic        b_rx_ready, b_WE, b_cpu_hold, b_done, b_err;
  logic [7:0]  b_WA;
  logic [31:0] b_WD;
  logic [6:0]  b_words;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imem_loader #(.N(8), .BASE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(a_rx_ready),
    .WE(a_WE), .WA(a_WA), .WD(a_WD), .cpu_hold(a_cpu_hold),
    .done(a_done), .err(a_err), .words(a_words)
  );

  imem_loader #(.N(8), .BASE(248)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(b_rx_ready),
    .WE(b_WE), .WA(b_WA), .WD(b_WD), .cpu_hold(b_cpu_hold),
    .done(b_done), .err(b_err), .words(b_words)
  );

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];
  wr_t m_q[$];
  int  m_words, m_acc;
  bit  m_err, m_done;

  logic [7:0] sb[64];
  int         sn;

  // Write monitors: one queue entry per cycle with WE high.
  always @(negedge clk) begin
    if (a_WE) q_a.push_back('{a: a_WA, d: a_WD});
    if (b_WE) q_b.push_back('{a: b_WA, d: b_WD});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_rdy(input int sel);
    return (sel != 0) ? b_rx_ready : a_rx_ready;
  endfunction

  // Reference model: chop the stream into 4-byte chunks, one write per chunk
  // at base+4k; a short trailing chunk is written only if it ends in last.
  task automatic model_run(input int base, input bit lastf);
    int addr, i, c;
    logic [31:0] w;
    m_q.delete();
    m_words = 0; m_acc = 0; m_err = 0; m_done = 0;
    addr = base; i = 0;
    while (i < sn) begin
      c = (sn - i < 4) ? (sn - i) : 4;
      if (c < 4 && !lastf) begin
        m_acc += c;
        break;
      end
      w = 0;
      for (int k = 0; k < c; k++) w = w + (32'(sb[i + k]) << (8 * k));
      m_q.push_back('{a: 8'(addr), d: w});
      m_words++;
      m_acc += c;
      i += c;
      if (i == sn && lastf) begin m_done = 1; break; end
      if (addr == 252) begin m_err = 1; break; end
      addr += 4;
    end
  endtask

  task automatic reset_all();
    rx_valid = 0; rx_last = 0; start = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    q_a.delete(); q_b.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  // Send sb[0..sn-1]; gap idle cycles after each accept; optional start pulse
  // on byte start_at. Stops when a byte waits 20 cycles without acceptance.
  task automatic drive(input int sel, input bit lastf, input int gap,
                       input int start_at, output int acc);
    bit got;
    acc = 0;
    for (int i = 0; i < sn; i++) begin
      rx_data = sb[i]; rx_valid = 1; rx_last = lastf && (i == sn - 1);
      if (i == start_at) start = 1;
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk); got = sel_rdy(sel);
        @(posedge clk); #1 start = 0;
      end
      if (!got) break;
      acc++;
      rx_valid = 0; rx_last = 0;
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end
    rx_valid = 0; rx_last = 0; start = 0;
  endtask

  task automatic run_session(input string tag, input int sel, input bit lastf,
                             input int gap, input int start_at);
    int acc;
    wr_t q[$];
    reset_all();
    pulse_start();
    @(negedge clk);
    chk({tag, ".hold_load"}, 32'((sel != 0) ? b_cpu_hold : a_cpu_hold), 32'd1);
    chk({tag, ".ready_load"}, 32'(sel_rdy(sel)), 32'd1);
    @(posedge clk); #1;
    drive(sel, lastf, gap, start_at, acc);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if ((sel != 0) ? (b_done | b_err) : (a_done | a_err)) break;
    end
    @(negedge clk);
    model_run((sel != 0) ? 248 : 0, lastf);
    q = (sel != 0) ? q_b : q_a;
    chk({tag, ".accepted"}, 32'(acc), 32'(m_acc));
    chk({tag, ".nwrites"}, 32'(q.size()), 32'(m_q.size()));
    for (int k = 0; k < q.size() && k < m_q.size(); k++) begin
      chk({tag, ".WA"}, 32'(q[k].a), 32'(m_q[k].a));
      chk({tag, ".WD"}, q[k].d, m_q[k].d);
    end
    chk({tag, ".done"},  32'((sel != 0) ? b_done  : a_done),  32'(m_done));
    chk({tag, ".err"},   32'((sel != 0) ? b_err   : a_err),   32'(m_err));
    chk({tag, ".words"}, 32'((sel != 0) ? b_words : a_words), 32'(m_words));
    chk({tag, ".hold"},  32'((sel != 0) ? b_cpu_hold : a_cpu_hold), 32'(!m_done));
    if (m_err) chk({tag, ".ready_err"}, 32'(sel_rdy(sel)), 32'd0);
    $display("session %s: sel=%0d bytes=%0d writes=%0d done=%0d err=%0d",
             tag, sel, sn, q.size(), m_done, m_err);
  endtask

  task automatic load_prog1();
    sn = 8;
    sb[0] = 8'h13; sb[1] = 8'h00; sb[2] = 8'h00; sb[3] = 8'h00;
    sb[4] = 8'h93; sb[5] = 8'h00; sb[6] = 8'h50; sb[7] = 8'h00;
  endtask

  initial begin
    int acc;
    // Reset values of both instances.
    reset_all();
    @(negedge clk);
    chk("rst.ready", 32'(a_rx_ready), 0);
    chk("rst.we",    32'(a_WE), 0);
    chk("rst.wa",    32'(a_WA), 0);
    chk("rst.wd",    a_WD, 0);
    chk("rst.hold",  32'(a_cpu_hold), 0);
    chk("rst.done",  32'(a_done), 0);
    chk("rst.err",   32'(a_err), 0);
    chk("rst.words", 32'(a_words), 0);
    chk("rst.wa_b",  32'(b_WA), 32'hF8);

    load_prog1();
    run_session("prog1", 0, 1, 0, -1);
    sn = 2; sb[0] = 8'h37; sb[1] = 8'h12;
    run_session("short", 0, 1, 0, -1);
    load_prog1();
    run_session("gaps", 0, 1, 3, -1);
    sn = 12;
    for (int i = 0; i < 12; i++) sb[i] = 8'($urandom);
    run_session("ovf", 1, 0, 0, -1);
    load_prog1();
    run_session("start_mid", 0, 1, 1, 5);

    // Reset in the middle of the second word.
    reset_all();
    pulse_start();
    sn = 6;
    for (int i = 0; i < 6; i++) sb[i] = 8'(i + 1);
    drive(0, 0, 0, -1, acc);
    chk("mid.acc", 32'(acc), 6);
    #2 rst_n = 0;
    #1;
    chk("mid.we",    32'(a_WE), 0);
    chk("mid.wa",    32'(a_WA), 0);
    chk("mid.wd",    a_WD, 0);
    chk("mid.hold",  32'(a_cpu_hold), 0);
    chk("mid.ready", 32'(a_rx_ready), 0);
    chk("mid.words", 32'(a_words), 0);
    chk("mid.done",  32'(a_done | a_err), 0);
    @(negedge clk); rst_n = 1;
    q_a.delete();
    pulse_start();
    sn = 4; sb[0] = 8'hAA; sb[1] = 8'hBB; sb[2] = 8'hCC; sb[3] = 8'hDD;
    drive(0, 0, 0, -1, acc);
    repeat (3) @(negedge clk);
    chk("mid.nwr", 32'(q_a.size()), 1);
    if (q_a.size() > 0) begin
      chk("mid.wa2", 32'(q_a[0].a), 0);
      chk("mid.wd2", q_a[0].d, 32'hDDCCBBAA);
    end
    chk("mid.words2", 32'(a_words), 1);
    $display("session reset_mid: writes=%0d", q_a.size());

    // Randomized sessions.
    for (int r = 0; r < 10; r++) begin
      int sel;
      sel = $urandom_range(0, 1);
      sn = $urandom_range(1, 20);
      for (int i = 0; i < sn; i++) sb[i] = 8'($urandom);
      run_session($sformatf("rand%0d", r), sel, ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 2), (r % 3 == 0) ? 2 : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
